// File: rtl/floor_pkg.sv
// rtl/floor_pkg.sv - shared types and constants for the floor request panel
package floor_pkg;

  localparam int FLOOR_W        = 3;
  localparam int NUM_FLOORS_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_ACK,
    ST_WAIT_DONE,
    ST_CLEAR
  } panel_state_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - per-bit 2-flop synchronizer with optional stable-sample filter
// PANEL_DEBOUNCE_EN adds the DEBOUNCE_CYCLES filter behind the synchronizer.
module btn_debounce #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] level_o
);

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef PANEL_DEBOUNCE_EN
  localparam int               CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] stable_q;
  logic [CNT_W-1:0] cnt_q [WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_q <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2_q[i] == stable_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          stable_q[i] <= sync2_q[i];
          cnt_q[i]    <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // The final agreeing sample is passed straight through so the new level is
  // visible in the same cycle it is accepted rather than one cycle later.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      level_o[i] = (cnt_q[i] == CNT_LAST) ? sync2_q[i] : stable_q[i];
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = (DEBOUNCE_CYCLES > 0);
  assign level_o    = sync2_q;
`endif

endmodule

// File: rtl/floor_request_panel.sv
// rtl/floor_request_panel.sv - hall-call panel latching button presses and issuing floor requests
// PANEL_DEBOUNCE_EN selects the filtered button path inside btn_debounce.
module floor_request_panel
  import floor_pkg::*;
#(
  parameter int NUM_FLOORS      = NUM_FLOORS_DEF,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ACK_TIMEOUT     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_FLOORS-1:0] btn,
  input  logic [FLOOR_W-1:0]    car_floor,
  input  logic                  car_complete,
  input  logic                  car_over_weight,
  output logic [FLOOR_W-1:0]    req_floor,
  output logic                  req_valid,
  output logic [NUM_FLOORS-1:0] lamp,
  output logic                  busy,
  output logic                  ack_err
);

  localparam int               TMO_W    = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

  panel_state_e          state_q;
  dir_e                  last_dir_q;
  logic [FLOOR_W-1:0]    target_q;
  logic [FLOOR_W-1:0]    req_floor_q;
  logic                  req_valid_q;
  logic                  ack_err_q;
  logic [TMO_W-1:0]      tmo_q;
  logic [NUM_FLOORS-1:0] pending_q;
  logic [NUM_FLOORS-1:0] pending_d;
  logic [NUM_FLOORS-1:0] level;
  logic [NUM_FLOORS-1:0] level_prev_q;
  logic [NUM_FLOORS-1:0] rise;
  logic [NUM_FLOORS-1:0] accept;

  logic                  up_found;
  logic                  dn_found;
  logic                  here_pending;
  logic [FLOOR_W-1:0]    up_floor;
  logic [FLOOR_W-1:0]    dn_floor;
  logic [FLOOR_W-1:0]    sel_floor;
  dir_e                  sel_dir;

  btn_debounce #(
    .WIDTH           (NUM_FLOORS),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk     (clk),
    .rst_n   (rst_n),
    .raw_i   (btn),
    .level_o (level)
  );

  assign rise = level & ~level_prev_q;

  // Floor 0 is the elevator's idle code, so bit 0 can never be requested.
  always_comb begin
    accept = '0;
    for (int i = 1; i < NUM_FLOORS; i++) begin
      accept[i] = rise[i] && !pending_q[i];
      if (state_q == ST_IDLE && car_complete && car_floor == FLOOR_W'(i)) accept[i] = 1'b0;
      if (state_q == ST_CLEAR && target_q == FLOOR_W'(i)) accept[i] = 1'b0;
    end
    pending_d = pending_q | accept;
    if (state_q == ST_CLEAR) pending_d[target_q] = 1'b0;
  end

  always_comb begin
    up_found = 1'b0;
    dn_found = 1'b0;
    up_floor = '0;
    dn_floor = '0;
    for (int i = NUM_FLOORS - 1; i > 0; i--) begin
      if (pending_q[i] && FLOOR_W'(i) > car_floor) begin
        up_found = 1'b1;
        up_floor = FLOOR_W'(i);
      end
    end
    for (int i = 1; i < NUM_FLOORS; i++) begin
      if (pending_q[i] && FLOOR_W'(i) < car_floor) begin
        dn_found = 1'b1;
        dn_floor = FLOOR_W'(i);
      end
    end
    if ((last_dir_q == DIR_UP && up_found) || !dn_found) begin
      sel_floor = up_floor;
      sel_dir   = DIR_UP;
    end else begin
      sel_floor = dn_floor;
      sel_dir   = DIR_DOWN;
    end
  end

  // A call latched at the car's own floor while it was moving is served in
  // place; issuing it would never see the car leave and would only time out.
  assign here_pending = pending_q[car_floor];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_dir_q   <= DIR_UP;
      target_q     <= '0;
      req_floor_q  <= '0;
      req_valid_q  <= 1'b0;
      ack_err_q    <= 1'b0;
      tmo_q        <= '0;
      pending_q    <= '0;
      level_prev_q <= '0;
    end else begin
      pending_q    <= pending_d;
      level_prev_q <= level;
      req_valid_q  <= 1'b0;
      ack_err_q    <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (pending_q != '0 && car_complete && !car_over_weight) begin
            if (here_pending) begin
              target_q <= car_floor;
              state_q  <= ST_CLEAR;
            end else begin
              target_q    <= sel_floor;
              req_floor_q <= sel_floor;
              req_valid_q <= 1'b1;
              last_dir_q  <= sel_dir;
              state_q     <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          tmo_q   <= '0;
          state_q <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          if (!car_over_weight) begin
            if (!car_complete) begin
              state_q <= ST_WAIT_DONE;
            end else if (tmo_q == TMO_LAST) begin
              ack_err_q <= 1'b1;
              state_q   <= ST_IDLE;
            end else begin
              tmo_q <= tmo_q + 1'b1;
            end
          end
        end
        ST_WAIT_DONE: begin
          if (!car_over_weight && car_complete && car_floor == target_q) state_q <= ST_CLEAR;
        end
        ST_CLEAR: state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_floor = req_floor_q;
  assign req_valid = req_valid_q;
  assign lamp      = pending_q;
  assign busy      = (state_q != ST_IDLE);
  assign ack_err   = ack_err_q;

endmodule

// File: tb/tb_floor_request_panel.sv
// tb/tb_floor_request_panel.sv - press-filter vector table plus issued-floor scoreboard
// Glitch rejection is exercised only when PANEL_DEBOUNCE_EN is defined.
module tb_floor_request_panel;

  localparam int NF = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NF-1:0] btn;
  logic [2:0]    car_floor;
  logic          car_complete;
  logic          car_over_weight;
  logic [2:0]    req_floor;
  logic          req_valid;
  logic [NF-1:0] lamp;
  logic          busy;
  logic          ack_err;

  always #5 clk = ~clk;

  floor_request_panel #(
    .NUM_FLOORS      (NF),
    .DEBOUNCE_CYCLES (4),
    .ACK_TIMEOUT     (16)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .btn             (btn),
    .car_floor       (car_floor),
    .car_complete    (car_complete),
    .car_over_weight (car_over_weight),
    .req_floor       (req_floor),
    .req_valid       (req_valid),
    .lamp            (lamp),
    .busy            (busy),
    .ack_err         (ack_err)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [2:0] exp_q[$];
  int         issue_cnt = 0;
  int         ack_cnt   = 0;
  int         issue_cyc = 0;
  int         ack_cyc   = 0;
  logic       ack_busy  = 1'b0;
  logic [7:0] ack_lamp  = '0;
  logic       prev_rv   = 1'b0;
  logic       prev_ae   = 1'b0;

  typedef struct {
    logic [2:0] cf;
    logic [7:0] b;
    logic [7:0] exp_lamp;
  } vec_t;
  vec_t vecs[6];

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && req_valid) begin
      issue_cnt++;
      issue_cyc = cyc;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_extra_issue: got floor %0d want none", req_floor);
      end else begin
        chk("sb_issue_floor", req_floor, exp_q.pop_front());
      end
      if (prev_rv) begin
        total++;
        bad++;
        $display("FAIL req_valid_width: got 2+ cycles want 1");
      end
    end
    if (rst_n && ack_err) begin
      ack_cnt++;
      ack_cyc  = cyc;
      ack_busy = busy;
      ack_lamp = lamp;
      if (prev_ae) begin
        total++;
        bad++;
        $display("FAIL ack_err_width: got 2+ cycles want 1");
      end
    end
    prev_rv = rst_n && req_valid;
    prev_ae = rst_n && ack_err;
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    btn   = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic press(input logic [NF-1:0] m);
    @(negedge clk);
    btn = m;
    repeat (8) @(negedge clk);
    btn = '0;
  endtask

  task automatic wait_issues(input int n, input string name);
    int k;
    k = 0;
    while (issue_cnt < n && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk(name, issue_cnt, n);
  endtask

  task automatic serve(input logic [2:0] f);
    @(negedge clk);
    car_complete = 1'b0;
    repeat (3) @(negedge clk);
    car_floor    = f;
    car_complete = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int base;
    int ab;
    int c0;
    int k;

    vecs[0] = '{3'd1, 8'h01, 8'h00};
    vecs[1] = '{3'd3, 8'h08, 8'h00};
    vecs[2] = '{3'd3, 8'h24, 8'h24};
    vecs[3] = '{3'd5, 8'h24, 8'h24};
    vecs[4] = '{3'd0, 8'h81, 8'hA4};
    vecs[5] = '{3'd1, 8'h42, 8'hE4};

    rst_n           = 1'b0;
    btn             = '0;
    car_floor       = 3'd0;
    car_complete    = 1'b1;
    car_over_weight = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_lamp", lamp, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_valid", req_valid, 0);
    chk("rst_req_floor", req_floor, 0);
    chk("rst_ack_err", ack_err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Press acceptance table: over-weight keeps the panel in IDLE throughout.
    car_over_weight = 1'b1;
    for (int i = 0; i < 6; i++) begin
      car_floor = vecs[i].cf;
      press(vecs[i].b);
      repeat (6) @(negedge clk);
      chk($sformatf("vec%0d_lamp", i), lamp, vecs[i].exp_lamp);
    end
    chk("vec_no_issue", issue_cnt, 0);
    do_reset();
    car_over_weight = 1'b0;

    car_floor = 3'd2;
    press(8'h05);
    repeat (6) @(negedge clk);
    chk("t36_lamp", lamp, 0);
    chk("t36_no_issue", issue_cnt, 0);

    car_floor = 3'd1;
    exp_q.push_back(3'd5);
    press(8'h20);
    wait_issues(1, "t34_issue");
    chk("t34_lamp_set", lamp, 8'h20);
    chk("t34_busy", busy, 1);
    serve(3'd5);
    chk("t34_lamp_clr", lamp, 0);
    chk("t34_idle", busy, 0);

    do_reset();
    car_over_weight = 1'b1;
    car_floor       = 3'd4;
    press(8'hC4);
    repeat (6) @(negedge clk);
    chk("t35_lamp", lamp, 8'hC4);
    exp_q.push_back(3'd6);
    exp_q.push_back(3'd7);
    exp_q.push_back(3'd2);
    base = issue_cnt;
    car_over_weight = 1'b0;
    wait_issues(base + 1, "t35_issue1");
    serve(3'd6);
    chk("t35_lamp_after6", lamp, 8'h84);
    wait_issues(base + 2, "t35_issue2");
    serve(3'd7);
    chk("t35_lamp_after7", lamp, 8'h04);
    wait_issues(base + 3, "t35_issue3");
    serve(3'd2);
    chk("t35_lamp_done", lamp, 0);
    chk("t35_idle", busy, 0);

    do_reset();
    car_floor = 3'd1;
    exp_q.push_back(3'd3);
    exp_q.push_back(3'd3);
    base = issue_cnt;
    ab   = ack_cnt;
    press(8'h08);
    wait_issues(base + 1, "t37_issue");
    c0 = issue_cyc;
    k  = 0;
    while (ack_cnt == ab && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk("t37_ack_count", ack_cnt, ab + 1);
    chk("t37_ack_latency", ack_cyc - c0, 17);
    chk("t37_idle_at_ack", ack_busy, 0);
    chk("t37_lamp3_kept", ack_lamp[3], 1);
    wait_issues(base + 2, "t37_reissue");
    serve(3'd3);
    chk("t37_lamp_clr", lamp, 0);

    do_reset();
    car_floor = 3'd1;
    exp_q.push_back(3'd4);
    base = issue_cnt;
    ab   = ack_cnt;
    press(8'h10);
    wait_issues(base + 1, "t38_issue");
    @(negedge clk);
    car_complete = 1'b0;
    repeat (2) @(negedge clk);
    car_over_weight = 1'b1;
    car_floor       = 3'd4;
    car_complete    = 1'b1;
    press(8'h40);
    repeat (12) @(negedge clk);
    chk("t38_busy_frozen", busy, 1);
    chk("t38_lamp", lamp, 8'h50);
    chk("t38_no_ack", ack_cnt, ab);
    exp_q.push_back(3'd6);
    car_over_weight = 1'b0;
    repeat (4) @(negedge clk);
    chk("t38_lamp_after_clear", lamp, 8'h40);
    wait_issues(base + 2, "t38_issue6");
    serve(3'd6);
    chk("t38_lamp_done", lamp, 0);

    do_reset();
    car_floor = 3'd1;
    exp_q.push_back(3'd5);
    base = issue_cnt;
    press(8'h20);
    wait_issues(base + 1, "t39_issue");
    @(negedge clk);
    car_complete = 1'b0;
    repeat (3) @(negedge clk);
    chk("t39_busy_before", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t39_async_lamp", lamp, 0);
    chk("t39_async_busy", busy, 0);
    chk("t39_async_req_valid", req_valid, 0);
    chk("t39_async_req_floor", req_floor, 0);
    chk("t39_async_ack_err", ack_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("t39_no_reissue", issue_cnt, base + 1);

`ifdef PANEL_DEBOUNCE_EN
    car_complete    = 1'b1;
    car_over_weight = 1'b1;
    car_floor       = 3'd0;
    @(negedge clk);
    btn = 8'h04;
    repeat (2) @(negedge clk);
    btn = '0;
    repeat (10) @(negedge clk);
    chk("t39_glitch_lamp", lamp, 0);
    car_over_weight = 1'b0;
`endif

    chk("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
